// File: rtl/int_sequencer.sv
// rtl/int_sequencer.sv - 6502 RESET/NMI/IRQ/BRK sequencer: boundary hijack, 7-cycle counter, vector select.
// Define NMI_HIJACK_EN to let a late NMI retarget an in-flight IRQ/BRK sequence to the NMI vector.
module int_sequencer #(
  parameter int          SEQ_CYCLES = 7,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        READY,
  input  logic        SYNC,
  input  logic        brk_op,
  input  logic        NMI,
  input  logic        IRQ,
  input  logic        i_flag,
  output logic        force_brk,
  output logic        seq_active,
  output logic [2:0]  seq_cycle,
  output logic        suppress_wr,
  output logic [15:0] vector,
  output logic        b_flag,
  output logic        set_i,
  output logic        nmi_ack
);

  typedef enum logic [1:0] {RST_SEQ, IDLE, INT_SEQ} state_t;

  localparam logic [2:0] LAST_CYC = 3'(SEQ_CYCLES - 1);
  localparam logic [2:0] SETI_CYC = 3'(SEQ_CYCLES - 2);

  state_t state;
  logic   nmi_prev;
  logic   nmi_pend;
  logic   nmi_edge;
  logic   hw_int;
  logic   boundary;
  logic   at_seti;

  assign nmi_edge  = NMI & ~nmi_prev;
  assign hw_int    = nmi_pend | (IRQ & ~i_flag);
  assign boundary  = ~i_rst & (state == IDLE) & SYNC & READY;
  assign force_brk = boundary & hw_int;

  // set_i/nmi_ack are qualified by READY so a stalled cycle SEQ_CYCLES-2 never double-fires.
  assign at_seti = ~i_rst & (state != IDLE) & READY & (seq_cycle == SETI_CYC);
  assign set_i   = at_seti;
  assign nmi_ack = at_seti & (state == INT_SEQ) & (vector == NMI_VEC);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= RST_SEQ;
      seq_cycle   <= 3'd0;
      seq_active  <= 1'b1;
      suppress_wr <= 1'b1;
      vector      <= RST_VEC;
      b_flag      <= 1'b0;
      nmi_prev    <= 1'b1;
      nmi_pend    <= 1'b0;
    end else begin
      nmi_prev <= NMI;
      nmi_pend <= nmi_edge | (nmi_pend & ~nmi_ack);
      case (state)
        RST_SEQ: begin
          if (READY) begin
            if (seq_cycle == LAST_CYC) begin
              state       <= IDLE;
              seq_cycle   <= 3'd0;
              seq_active  <= 1'b0;
              suppress_wr <= 1'b0;
            end else begin
              seq_cycle <= seq_cycle + 3'd1;
            end
          end
        end
        IDLE: begin
          // A hardware interrupt beats a simultaneous BRK; the BRK opcode is re-fetched afterwards.
          if (boundary && (hw_int || brk_op)) begin
            state      <= INT_SEQ;
            seq_cycle  <= 3'd1;
            seq_active <= 1'b1;
            b_flag     <= ~hw_int;
            vector     <= nmi_pend ? NMI_VEC : IRQ_VEC;
          end
        end
        INT_SEQ: begin
          if (READY) begin
`ifdef NMI_HIJACK_EN
            if (nmi_pend && (seq_cycle < SETI_CYC))
              vector <= NMI_VEC;
`endif
            if (seq_cycle == LAST_CYC) begin
              state      <= IDLE;
              seq_cycle  <= 3'd0;
              seq_active <= 1'b0;
            end else begin
              seq_cycle <= seq_cycle + 3'd1;
            end
          end
        end
        default: state <= RST_SEQ;
      endcase
    end
  end

endmodule
